// File: rtl/alu_seq_if.sv
// alu_seq_if: operand entry, button and result/status bundle for alu_seq.
//   sw[3:0]    operand value, two's complement   (master -> slave)
//   op[2:0]    operation select                  (master -> slave)
//   btn        raw push button, active-high      (master -> slave)
//   out[3:0]   registered result                 (slave -> master)
//   carry      carry (add) / no-borrow (sub)     (slave -> master)
//   overflow   signed overflow                   (slave -> master)
//   zero       result is zero                    (slave -> master)
//   valid      fresh result displayed            (slave -> master)
//   state[1:0] current FSM state code            (slave -> master)
interface alu_seq_if;
    logic [3:0] sw;
    logic [2:0] op;
    logic       btn;
    logic [3:0] out;
    logic       carry;
    logic       overflow;
    logic       zero;
    logic       valid;
    logic [1:0] state;

    modport master (
        output sw, op, btn,
        input  out, carry, overflow, zero, valid, state
    );

    modport slave (
        input  sw, op, btn,
        output out, carry, overflow, zero, valid, state
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: sequential 4-bit two's-complement ALU. Operand A then B are
// entered on the switches, each accepted on a debounced button press; the
// selected operation then executes for one cycle and the result and flags
// are held for the display stage until the next execution.
//   clk  system clock
//   rst  synchronous, active-high reset
//   bus  alu_seq_if.slave: sw/op/btn in, out/carry/overflow/zero/valid/state out
module alu_seq #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    alu_seq_if.slave   bus
);
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        LOAD_A = 2'b00,
        LOAD_B = 2'b01,
        EXEC   = 2'b10,
        SHOW   = 2'b11
    } state_e;

    state_e        state_q, state_d;
    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d_q;
    logic [CW-1:0] cnt_q;
    logic          step;

    logic [3:0]    a_q, b_q, out_q;
    logic          carry_q, ovf_q, zero_q;
    logic [3:0]    res_out;
    logic          res_c, res_v;
    logic [4:0]    sum5, diff5;

    // Button synchronizer and debouncer.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            stable_q   <= 1'b0;
            stable_d_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            sync1_q    <= bus.btn;
            sync2_q    <= sync1_q;
            stable_d_q <= stable_q;
            if (sync2_q != stable_q) begin
                // The increment that would reach DEBOUNCE_CYCLES accepts the level instead.
                if (cnt_q == DB_LAST) begin
                    stable_q <= sync2_q;
                    cnt_q    <= '0;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign step = stable_q & ~stable_d_q;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= LOAD_A;
        else     state_q <= state_d;
    end

    // FSM next state; a step during EXEC is dropped, not queued.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LOAD_A: if (step) state_d = LOAD_B;
            LOAD_B: if (step) state_d = EXEC;
            EXEC:             state_d = SHOW;
            SHOW:   if (step) state_d = LOAD_A;
            default:          state_d = LOAD_A;
        endcase
    end

    // FSM outputs.
    always_comb begin
        bus.valid = (state_q == SHOW);
        bus.state = state_q;
    end

    // Combinational ALU on the latched operands.
    always_comb begin
        sum5    = {1'b0, a_q} + {1'b0, b_q};
        diff5   = {1'b0, a_q} + {1'b0, ~b_q} + 5'd1;
        res_out = '0;
        res_c   = 1'b0;
        res_v   = 1'b0;
        case (bus.op)
            3'b000: begin
                res_out = sum5[3:0];
                res_c   = sum5[4];
                res_v   = (a_q[3] == b_q[3]) && (sum5[3] != a_q[3]);
            end
            3'b001: begin
                res_out = diff5[3:0];
                res_c   = diff5[4];
                res_v   = (a_q[3] != b_q[3]) && (diff5[3] != a_q[3]);
            end
            3'b010:  res_out = ~a_q;
            3'b011:  res_out = a_q & b_q;
            3'b100:  res_out = a_q | b_q;
            3'b101:  res_out = a_q ^ b_q;
            3'b110:  res_out = {3'b000, ($signed(a_q) < $signed(b_q))};
            default: res_out = {3'b000, (a_q == b_q)};
        endcase
    end

    // Operand and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            out_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            if (state_q == LOAD_A && step) a_q <= bus.sw;
            if (state_q == LOAD_B && step) b_q <= bus.sw;
            if (state_q == EXEC) begin
                out_q   <= res_out;
                carry_q <= res_c;
                ovf_q   <= res_v;
                zero_q  <= (res_out == '0);
            end
        end
    end

    assign bus.out      = out_q;
    assign bus.carry    = carry_q;
    assign bus.overflow = ovf_q;
    assign bus.zero     = zero_q;
endmodule

// File: doc/alu_seq.md
# alu_seq

Sequential 4-bit two's-complement ALU, directly upstream of the seven-segment sign/magnitude display stage. The user enters operand A, then operand B, on four switches, advancing with one debounced push button. The block then executes the selected operation and holds the 4-bit result and flags. `out` drives the display stage's 4-bit signed input unchanged; the flags and state drive LEDs.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronized samples required before a button level change is accepted; legal range 2..2^20.
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `sw`  in  4  operand value, two's complement
- `op`  in  3  operation select, sampled in EXEC
- `btn`  in  1  raw push button, active-high, asynchronous/bouncy
- `out`  out  4  registered result, two's complement
- `carry`  out  1  registered carry (add) / no-borrow (sub)
- `overflow`  out  1  registered signed overflow
- `zero`  out  1  registered, high when `out` == 0
- `valid`  out  1  high while a fresh result is displayed (state SHOW)
- `state`  out  2  current FSM state code

## Operation
- Button path:
  - Two-flop synchronizer on `btn`.
  - Debounce counter increments each cycle the synchronized level differs from the accepted level `btn_stable`; any cycle they match clears it.
  - When the counter would reach `DEBOUNCE_CYCLES`, `btn_stable` takes the synchronized level and the counter clears.
  - `step` is a one-cycle pulse on the rising edge of `btn_stable` (`btn_stable & ~btn_stable_d`).
- FSM (code in brackets). All transitions occur on the clock edge where the condition holds.
  - LOAD_A [00]: on `step`, A <= `sw`, go LOAD_B.
  - LOAD_B [01]: on `step`, B <= `sw`, go EXEC.
  - EXEC [10]: unconditional, one cycle. Compute from A, B, `op`; register `out`/flags; go SHOW.
  - SHOW [11]: on `step`, go LOAD_A.
- `step` in EXEC is ignored; it is not queued.
- `out` and flags change only on the EXEC edge and hold through LOAD_A/LOAD_B until the next EXEC.
- Operations (`op`):
  - 000 add: {carry,out} = A + B, 5-bit unsigned sum. overflow = (A[3]==B[3]) & (out[3]!=A[3]).
  - 001 sub: {carry,out} = A + ~B + 1, 5-bit. overflow = (A[3]!=B[3]) & (out[3]!=A[3]).
  - 010 not: out = ~A.
  - 011 and: out = A & B.
  - 100 or: out = A | B.
  - 101 xor: out = A ^ B.
  - 110 slt: out = 0001 if signed A < signed B, else 0000.
  - 111 eq: out = 0001 if A == B, else 0000.
  - For all non-arithmetic ops (010–111), carry = 0 and overflow = 0.
- `zero` = (out == 0) for every op.

## Timing
- Reset (edge with `rst`=1): `state`=LOAD_A, A=B=0, `out`=0000, `carry`=0, `overflow`=0, `zero`=1, `valid`=0. Synchronizer flops, `btn_stable`, `btn_stable_d` and the debounce counter are all 0. Reset dominates `step` and any state, including mid-EXEC/SHOW.
- Press latency: `btn` held high from edge N gives `step` high on edge N+2+DEBOUNCE_CYCLES+1 (±1 for input phase).
- Releases never generate `step`. A pulse or bounce shorter than DEBOUNCE_CYCLES produces no `step`.
- `valid` rises on the EXEC->SHOW edge and falls on the SHOW->LOAD_A edge.
- Result latency: `out` is valid 1 cycle after the LOAD_B `step` edge.
- `sw` is sampled only on `step` edges; `op` is sampled only in the EXEC cycle.

## Test plan
- Reset, hold: after `rst`, state=00, out=0000, zero=1, valid=0. Hold `btn` high through reset release and for >2·DEBOUNCE_CYCLES -> exactly one `step`, state=01.
- Add: A=0011, B=0100, op=000 -> out=0111, carry=0, overflow=0, zero=0, valid=1, state=11 one cycle after the B step.
- Add overflow: A=0111, B=0001 -> out=1000, overflow=1, carry=0. Sub: A=0010, B=0101 -> out=1101, carry=0, overflow=0.
- Sub overflow: A=1000, B=0001, op=001 -> out=0111, carry=1, overflow=1. Slt: A=1110, B=0001, op=110 -> out=0001, carry=0.
- Bounce: toggle `btn` with high pulses of DEBOUNCE_CYCLES-1 cycles, 10 times -> no `step`, state unchanged. A following clean press -> exactly one transition.
- Reset in SHOW with out=0111 -> next cycle out=0000, zero=1, valid=0, state=00. A press during EXEC (step coinciding with EXEC) -> ignored; state still reaches 11.
